// File: rtl/soc_system_matrix_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// soc_system_matrix_scan : 8x8 LED column-scan controller, double-buffered
//                          frame, Avalon-MM zero-wait-state slave
// Revision : 1.0
// ============================================================================
module soc_system_matrix_scan #(
  parameter int          BLANK_CYCLES = 4,
  parameter logic [15:0] DWELL_RESET  = 16'd5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  columns_out,
  output logic [7:0]  rows_out,
  output logic        frame_done
);

  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_DRIVE    = 2'd1;
  localparam logic [1:0]  S_BLANK    = 2'd2;
  localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam logic [15:0] BLANK_LOAD = HAS_BLANK ? 16'(BLANK_CYCLES - 1) : 16'd0;

  logic [1:0]  state, state_next;
  logic [2:0]  col, col_next;
  logic [15:0] cnt, cnt_next;
  logic [7:0]  front [8];
  logic [7:0]  back [8];
  logic [7:0]  front_next [8];
  logic        enable, commit;
  logic [15:0] dwell;
  logic [7:0]  frame_cnt;
  logic        wr, commit_wr, boundary, swap;
  logic [15:0] dwell_load;
  logic [7:0]  columns_next, rows_next;
  logic        unused_bits;

  assign wr          = chipselect & ~write_n;
  assign commit_wr   = wr && (address == 4'd8) && writedata[1];
  assign dwell_load  = (dwell == 16'd0) ? 16'd0 : dwell - 16'd1;
  assign unused_bits = ^writedata[31:16];

  // A commit written in the boundary cycle itself is honoured at that boundary.
  assign swap = ((state == S_IDLE) && commit) || (boundary && (commit || commit_wr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      col   <= 3'd0;
      cnt   <= 16'd0;
    end else begin
      state <= state_next;
      col   <= col_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    col_next   = col;
    cnt_next   = cnt;
    boundary   = 1'b0;
    case (state)
      S_IDLE: begin
        col_next = 3'd0;
        if (enable) begin
          state_next = S_DRIVE;
          cnt_next   = dwell_load;
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          state_next = S_IDLE;
          col_next   = 3'd0;
          cnt_next   = 16'd0;
        end else if (cnt != 16'd0) begin
          cnt_next = cnt - 16'd1;
        end else if (HAS_BLANK) begin
          state_next = S_BLANK;
          cnt_next   = BLANK_LOAD;
        end else begin
          col_next = col + 3'd1;
          cnt_next = dwell_load;
          boundary = (col == 3'd7);
        end
      end
      S_BLANK: begin
        if (!enable) begin
          state_next = S_IDLE;
          col_next   = 3'd0;
          cnt_next   = 16'd0;
        end else if (cnt != 16'd0) begin
          cnt_next = cnt - 16'd1;
        end else begin
          state_next = S_DRIVE;
          col_next   = col + 3'd1;
          cnt_next   = dwell_load;
          boundary   = (col == 3'd7);
        end
      end
      default: begin
        state_next = S_IDLE;
        col_next   = 3'd0;
        cnt_next   = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the drive lines are registered
  // yet aligned with the state they belong to, including freshly swapped data.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      front_next[i] = swap ? back[i] : front[i];
    end
    columns_next = 8'h00;
    rows_next    = 8'h00;
    if (state_next == S_DRIVE) begin
      columns_next = 8'h01 << col_next;
      rows_next    = front_next[col_next];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        front[i] <= 8'h00;
        back[i]  <= 8'h00;
      end
      enable      <= 1'b0;
      commit      <= 1'b0;
      dwell       <= DWELL_RESET;
      frame_cnt   <= 8'd0;
      columns_out <= 8'h00;
      rows_out    <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        front[i] <= front_next[i];
      end
      if (wr && !address[3]) begin
        back[address[2:0]] <= writedata[7:0];
      end
      if (wr && (address == 4'd8)) begin
        enable <= writedata[0];
      end
      if (swap) begin
        commit <= 1'b0;
      end else if (commit_wr) begin
        commit <= 1'b1;
      end
      if (wr && (address == 4'd9)) begin
        dwell <= writedata[15:0];
      end
      if (boundary) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      columns_out <= columns_next;
      rows_out    <= rows_next;
      frame_done  <= boundary;
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (!address[3]) begin
      readdata = {24'd0, back[address[2:0]]};
    end else begin
      case (address)
        4'd8:    readdata = {30'd0, commit, enable};
        4'd9:    readdata = {16'd0, dwell};
        4'd10:   readdata = {16'd0, frame_cnt, 4'd0, (state != S_IDLE), col};
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_matrix_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_soc_system_matrix_scan : directed bench with a cycle scoreboard for the
//                             LED matrix scan controller
// Revision : 1.0
// ============================================================================
module tb_soc_system_matrix_scan;

  localparam int D  = 3;
  localparam int B  = 2;
  localparam int P  = D + B;
  localparam int FP = 8 * P;

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] r;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = 4'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  columns_out;
  logic [7:0]  rows_out;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  exp_t q[$];
  int   lenq[$];

  logic [7:0] fm [8];
  logic [7:0] bm [8];
  bit         m_run, m_en, pend;
  int         m_s, fc;
  logic [7:0] cap [64];

  soc_system_matrix_scan #(.BLANK_CYCLES(B), .DWELL_RESET(16'd5000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .columns_out(columns_out),
    .rows_out   (rows_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic capture(input int n, input int wat, input logic [15:0] wval);
    for (int i = 0; i < n; i++) begin
      if (i == wat) begin
        chipselect = 1'b1; write_n = 1'b0; address = 4'd9; writedata = {16'd0, wval};
      end
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      cap[i] = columns_out;
    end
  endtask

  function automatic int count_val(input int n, input logic [7:0] v);
    int k = 0;
    for (int i = 0; i < n; i++) if (cap[i] == v) k++;
    return k;
  endfunction

  function automatic int first_idx(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) if (cap[i] == v) return i;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rdv;
    logic [7:0]  one8;
    bit          wnow, en_old, bnd, nxt_run, commit_now;
    int          nxt_s, pos, c;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    exp_t        e;

    one8 = 8'h01;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("reset_cols", {24'd0, columns_out}, 32'd0);
    chk("reset_rows", {24'd0, rows_out}, 32'd0);
    chk("reset_fd", {31'd0, frame_done}, 32'd0);
    rd(4'd9, rdv);  chk("reset_dwell", rdv, 32'd5000);
    rd(4'd10, rdv); chk("reset_status", rdv, 32'd0);
    rd(4'd8, rdv);  chk("reset_ctrl", rdv, 32'd0);
    rd(4'd12, rdv); chk("unused_reg", rdv, 32'd0);

    wr(4'd9, 32'd3);
    for (int k = 0; k < 8; k++) wr(4'(k), 32'(k + 1));
    wr(4'd8, 32'd2);
    rd(4'd8, rdv); chk("commit_pending_idle", rdv, 32'd2);
    @(negedge clk);
    rd(4'd8, rdv); chk("commit_clear_idle", rdv, 32'd0);
    rd(4'd5, rdv); chk("back5_read", rdv, 32'd6);

    for (int k = 0; k < 8; k++) begin
      fm[k] = 8'(k + 1);
      bm[k] = 8'(k + 1);
    end
    m_run = 0; m_en = 0; pend = 0; m_s = 0; fc = 0;
    q.push_back('{8'h00, 8'h00, 1'b0});

    for (int t = 0; t <= 300; t++) begin
      e = q.pop_front();
      chk("scan_cols", {24'd0, columns_out}, {24'd0, e.c});
      chk("scan_rows", {24'd0, rows_out}, {24'd0, e.r});
      chk("scan_fd", {31'd0, frame_done}, {31'd0, e.fd});

      chipselect = 1'b0; write_n = 1'b1;
      wnow = 0; waddr = 4'd0; wdata = 32'd0;
      if (t == 2 || t == 250) begin
        wnow = 1; waddr = 4'd8; wdata = 32'd1;
      end else if (t >= 50 && t <= 57) begin
        wnow = 1; waddr = 4'(t - 50); wdata = 32'hFF;
      end else if (t == 60 || t == 122 || t == 163) begin
        wnow = 1; waddr = 4'd8; wdata = 32'd3;
      end else if (t >= 95 && t <= 102) begin
        wnow = 1; waddr = 4'(t - 95); wdata = 32'h10 + 32'(t - 95);
      end else if (t == 123) begin
        wnow = 1; waddr = 4'd3; wdata = 32'hAA;
      end else if (t == 230) begin
        wnow = 1; waddr = 4'd8; wdata = 32'd0;
      end

      if (wnow) begin
        chipselect = 1'b1; write_n = 1'b0; address = waddr; writedata = wdata;
      end else if (t == 20 || t == 240 || t == 280) begin
        c = m_run ? (m_s % FP) / P : 0;
        rd(4'd10, rdv);
        chk("status", rdv, {16'd0, 8'(fc), 4'd0, m_run, 3'(c)});
      end else if (t == 70 || t == 90 || t == 170) begin
        rd(4'd8, rdv);
        chk("ctrl", rdv, {30'd0, pend, m_en});
      end else if (t == 130) begin
        rd(4'd3, rdv);
        chk("back3_after_swap", rdv, {24'd0, bm[3]});
      end

      en_old = m_en; bnd = 0; nxt_run = m_run; nxt_s = m_s;
      if (m_run) begin
        if (!en_old) nxt_run = 0;
        else begin
          nxt_s = m_s + 1;
          bnd = ((m_s % FP) == FP - 1);
        end
      end else if (en_old) begin
        nxt_run = 1; nxt_s = 0;
      end
      commit_now = wnow && (waddr == 4'd8) && wdata[1];
      if ((!m_run && pend) || (bnd && (pend || commit_now))) begin
        for (int k = 0; k < 8; k++) fm[k] = bm[k];
        pend = 0;
      end else if (commit_now) begin
        pend = 1;
      end
      if (wnow && !waddr[3]) bm[waddr[2:0]] = wdata[7:0];
      if (wnow && waddr == 4'd8) m_en = wdata[0];
      if (bnd) fc++;
      m_run = nxt_run; m_s = nxt_s;

      if (m_run) begin
        pos = m_s % FP;
        c = pos / P;
        if ((pos % P) < D) q.push_back('{one8 << c, fm[c], bnd});
        else q.push_back('{8'h00, 8'h00, bnd});
      end else begin
        q.push_back('{8'h00, 8'h00, bnd});
      end

      @(negedge clk);
    end

    wr(4'd8, 32'd0);
    wr(4'd9, 32'd0);
    wr(4'd8, 32'd1);
    lenq.push_back(1); lenq.push_back(1); lenq.push_back(1 + B);
    capture(12, -1, 16'd0);
    chk("dwell0_col0_len", 32'(count_val(12, 8'h01)), 32'(lenq.pop_front()));
    chk("dwell0_col1_len", 32'(count_val(12, 8'h02)), 32'(lenq.pop_front()));
    chk("dwell0_col1_start", 32'(first_idx(12, 8'h02)), 32'(lenq.pop_front()));

    wr(4'd8, 32'd0);
    wr(4'd9, 32'd3);
    wr(4'd8, 32'd1);
    lenq.push_back(3); lenq.push_back(6); lenq.push_back(3 + B); lenq.push_back(0);
    capture(14, 1, 16'd6);
    chk("dwchg_col0_len", 32'(count_val(14, 8'h01)), 32'(lenq.pop_front()));
    chk("dwchg_col1_len", 32'(count_val(14, 8'h02)), 32'(lenq.pop_front()));
    chk("dwchg_col1_start", 32'(first_idx(14, 8'h02)), 32'(lenq.pop_front()));
    chk("dwchg_col0_start", 32'(first_idx(14, 8'h01)), 32'(lenq.pop_front()));

    chk("pre_reset_cols", {24'd0, columns_out}, 32'h04);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_cols", {24'd0, columns_out}, 32'd0);
    chk("async_reset_rows", {24'd0, rows_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd9, rdv);  chk("post_reset_dwell", rdv, 32'd5000);
    rd(4'd10, rdv); chk("post_reset_status", rdv, 32'd0);
    rd(4'd3, rdv);  chk("post_reset_back3", rdv, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {23'd0, frame_done, columns_out}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
